// File: rtl/ss_frame_deserializer.sv
// rtl/ss_frame_deserializer.sv - start/data/parity/stop serial frame receiver with good-frame counter
module ss_frame_deserializer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [3:0]           frame_cnt
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift_buf, shift_buf_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 par_bit, par_bit_nxt;
  logic                 parity_ok;
  logic                 valid_nxt, perr_nxt, ferr_nxt;
  logic [3:0]           cnt_nxt;

  // Even parity over data plus parity bit; always good when no parity bit is sent
  assign parity_ok = (PARITY_EN != 0) ? ~(^shift_buf ^ par_bit) : 1'b1;
  assign busy      = (state != IDLE);

  // Next-state and datapath decode; a low line in BREAK is never a start bit
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_buf_nxt = shift_buf;
    par_bit_nxt   = par_bit;
    data_nxt      = data_out;
    cnt_nxt       = frame_cnt;
    valid_nxt     = 1'b0;
    perr_nxt      = 1'b0;
    ferr_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (!serial_in) begin
          state_nxt     = DATA;
          bit_cnt_nxt   = '0;
          shift_buf_nxt = '0;
          par_bit_nxt   = 1'b0;
        end
      end
      DATA: begin
        for (int i = 0; i < DATA_BITS; i++) begin
          if (bit_cnt == CW'(i)) shift_buf_nxt[i] = serial_in;
        end
        bit_cnt_nxt = bit_cnt + CW'(1);
        if (bit_cnt == LAST_BIT) begin
          state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_bit_nxt = serial_in;
        state_nxt   = STOP;
      end
      STOP: begin
        if (serial_in) begin
          data_nxt  = shift_buf;
          state_nxt = IDLE;
          if (parity_ok) begin
            valid_nxt = 1'b1;
            cnt_nxt   = frame_cnt + 4'd1;
          end else begin
            perr_nxt = 1'b1;
          end
        end else begin
          ferr_nxt  = 1'b1;
          state_nxt = BREAK;
        end
      end
      BREAK: begin
        if (serial_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; holds while the block is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers; pulses are cleared whenever ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shift_buf  <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      frame_cnt  <= 4'd0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else if (ena) begin
      bit_cnt    <= bit_cnt_nxt;
      shift_buf  <= shift_buf_nxt;
      par_bit    <= par_bit_nxt;
      data_out   <= data_nxt;
      frame_cnt  <= cnt_nxt;
      data_valid <= valid_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ss_frame_deserializer.sv
// tb/tb_ss_frame_deserializer.sv - table-driven bench for ss_frame_deserializer
module tb_ss_frame_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [3:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ss_frame_deserializer #(.DATA_BITS(8), .PARITY_EN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         brk;
    logic       ev;
    logic       ep;
    logic       ef;
    logic [7:0] ed;
    logic [3:0] ec;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one bit for one clock edge; returns at the following falling edge
  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start, data LSB first, parity; counts pulses seen before the stop bit
  task automatic send_body(input logic [7:0] d, input logic p, output int spur);
    spur = 0;
    send_bit(1'b0);
    if (data_valid || parity_err || frame_err) spur++;
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (data_valid || parity_err || frame_err) spur++;
    end
    send_bit(p);
    if (data_valid || parity_err || frame_err) spur++;
  endtask

  initial begin
    int spur;
    int errs;
    int last_cyc;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 4'd1};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h01, 4'd1};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1, 8'h01, 4'd1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h55, 4'd2};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h80, 4'd3};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hFF, 4'd4};
    vecs[6] = '{8'h07, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h07, 4'd4};
    vecs[7] = '{8'h07, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h07, 4'd5};

    // Reset and idle line
    rst_n = 1'b0; ena = 1'b1; serial_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst data_out", data_out, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst pulses", {data_valid, parity_err, frame_err}, 0);
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1);
      if (busy || data_valid || parity_err || frame_err || data_out != 0 || frame_cnt != 0) errs++;
    end
    chk("idle outputs", errs, 0);

    // Table of single frames, each followed by an idle bit
    for (int v = 0; v < 8; v++) begin
      send_body(vecs[v].d, vecs[v].p, spur);
      chk($sformatf("v%0d early pulse", v), spur, 0);
      send_bit(vecs[v].s);
      chk($sformatf("v%0d data_valid", v), data_valid, vecs[v].ev);
      chk($sformatf("v%0d parity_err", v), parity_err, vecs[v].ep);
      chk($sformatf("v%0d frame_err", v), frame_err, vecs[v].ef);
      chk($sformatf("v%0d data_out", v), data_out, vecs[v].ed);
      chk($sformatf("v%0d frame_cnt", v), frame_cnt, vecs[v].ec);
      if (vecs[v].brk > 0) begin
        errs = 0;
        for (int k = 0; k < vecs[v].brk; k++) begin
          send_bit(1'b0);
          if (!busy || data_valid || parity_err || frame_err) errs++;
        end
        chk($sformatf("v%0d break hold", v), errs, 0);
      end
      send_bit(1'b1);
      chk($sformatf("v%0d pulse width", v), {data_valid, parity_err, frame_err}, 0);
      chk($sformatf("v%0d busy after", v), busy, 0);
    end

    // Sixteen back-to-back frames from a fresh reset; count wraps to zero
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1);
    last_cyc = 0;
    errs = 0;
    for (int f = 0; f < 16; f++) begin
      b = 8'(f * 37 + 11);
      send_body(b, ^b, spur);
      if (spur != 0) errs++;
      send_bit(1'b1);
      if (!data_valid || data_out != b || frame_cnt != 4'(f + 1)) errs++;
      if (f > 0 && cyc - last_cyc != 11) errs++;
      last_cyc = cyc;
    end
    chk("b2b frames", errs, 0);
    chk("b2b wrap cnt", frame_cnt, 0);
    chk("b2b last data", data_out, 8'(15 * 37 + 11));
    send_bit(1'b1);

    // ena dropped for three cycles during data bit 4
    b = 8'h96;
    errs = 0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_bit(~b[4]);
      if (!busy || data_valid || parity_err || frame_err) errs++;
    end
    ena = 1'b1;
    for (int i = 4; i < 8; i++) send_bit(b[i]);
    send_bit(^b);
    send_bit(1'b1);
    chk("ena hold", errs, 0);
    chk("ena data_valid", data_valid, 1);
    chk("ena data_out", data_out, 8'h96);
    chk("ena frame_cnt", frame_cnt, 1);
    send_bit(1'b1);

    // Asynchronous reset during data bit 2
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    serial_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst frame_cnt", frame_cnt, 0);
    chk("mid rst data_out", data_out, 0);
    chk("mid rst pulses", {data_valid, parity_err, frame_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    for (int k = 0; k < 12; k++) begin
      send_bit(1'b1);
      if (busy || data_valid || parity_err || frame_err) errs++;
    end
    chk("post rst idle", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ss_frame_deserializer.md
# ss_frame_deserializer

Serial frame receiver that sits directly downstream of the serial-in/serial-out shift register in the Tiny Tapeout user design. It samples the register's one-bit-per-clock output stream, detects framed bytes, checks parity and stop bits, and presents each good byte in parallel with a one-cycle valid strobe. It also keeps a count of good frames for debug visibility on spare output pins.

## Interface
- `DATA_BITS`, default 8: payload bits per frame, sent LSB first.
- `PARITY_EN`, default 1: 1 = one even-parity bit follows the data; 0 = no parity bit.
- `clk` input, 1 bit: single clock; all sampling happens on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `ena` input, 1 bit: 1 = block active; 0 = freeze all state.
- `serial_in` input, 1 bit: bit stream from the shift register output, one bit per clock; the line idles high.
- `data_out` output, DATA_BITS bits: last byte received, registered.
- `data_valid` output, 1 bit: one-cycle pulse when a good frame is delivered.
- `parity_err` output, 1 bit: one-cycle pulse on a parity mismatch.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is 0.
- `busy` output, 1 bit: high in any state other than IDLE.
- `frame_cnt` output, 4 bits: count of good frames; wraps 15 to 0.

## Operation
- Frame format: start bit (0), then DATA_BITS data bits LSB first, then a parity bit if PARITY_EN=1, then a stop bit (1).
  - Default frame is 11 bits.
- Parity rule: the XOR of the data bits and the parity bit must equal 0.
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE: if `serial_in`=0, go to DATA, clear the bit counter and clear the shift buffer. Otherwise stay.
- DATA: shift `serial_in` into the buffer at position `bit_cnt`.
  - After DATA_BITS bits, go to PARITY if PARITY_EN=1, else STOP.
  - The bit counter is ceil(log2(DATA_BITS+1)) bits wide.
- PARITY: capture the parity bit and go to STOP.
- STOP, sampling `serial_in`:
  - 1 with parity OK: load the buffer into `data_out`, pulse `data_valid`, increment `frame_cnt`, go to IDLE.
  - 1 with parity bad: load `data_out` anyway, pulse `parity_err` only (no `data_valid`), `frame_cnt` unchanged, go to IDLE.
  - 0: pulse `frame_err`, leave `data_out` unchanged, go to BREAK. Parity is ignored in this case.
- BREAK: stay until `serial_in`=1, then go to IDLE. A low line is never taken as a new start bit.
- `ena`=0:
  - The FSM, counters, buffer and `data_out` hold.
  - `data_valid`, `parity_err` and `frame_err` are forced to 0.
  - Bits arriving while `ena`=0 are ignored, and the frame resumes when `ena` returns to 1.
- Reset: asynchronous assertion at any time, including mid-frame, forces IDLE. Reset values:
  - `data_out`=0
  - `data_valid`=`parity_err`=`frame_err`=0
  - `busy`=0
  - `frame_cnt`=0
  - internal buffer and counters = 0

## Timing
- Cycle numbering: the start bit is sampled on edge N.
  - Data bit k is sampled on edge N+1+k.
  - Parity is sampled on N+1+DATA_BITS.
  - Stop is sampled on N+2+DATA_BITS with parity enabled, or N+1+DATA_BITS without.
- Outputs: all outputs are registered.
  - `data_out`, `data_valid`, error pulses and `frame_cnt` update on the same edge that samples the stop bit.
  - They are visible for the following cycle, so latency from stop bit to valid is 1 cycle.
  - Pulses are exactly one cycle wide.
- `busy`: rises the cycle after the start edge, falls the cycle after the stop edge, and stays high throughout BREAK.
- Back-to-back frames: a start bit may appear on the cycle immediately after the stop bit. It is accepted with no idle gap, giving an 11-cycle frame period.
- Never simultaneous: `data_valid`, `parity_err` and `frame_err` are mutually exclusive.

## Test plan
- Reset, idle line: hold `rst_n`=0, then release with `serial_in`=1 for 20 cycles.
  - Required: all outputs stay 0, `busy`=0.
- Good byte 0xA5: send 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - Required: `data_out`=0xA5, a single `data_valid` pulse 1 cycle after the stop edge, `frame_cnt`=1.
- Parity error: send byte 0x01 with parity bit 0.
  - Required: `parity_err` pulse, `data_valid`=0, `data_out`=0x01, `frame_cnt` unchanged.
- Frame error and break: send 0x3C with stop bit 0, then hold the line 0 for 5 cycles, then 1, then frame 0x55.
  - Required: `frame_err` pulse, `data_out` keeps its prior value, no false start during the low cycles, then 0x55 valid.
- Back-to-back and wrap: send 16 consecutive good frames with no gaps.
  - Required: 16 `data_valid` pulses spaced 11 cycles apart, `frame_cnt` wraps to 0.
- ena and mid-frame reset: drop `ena` for 3 cycles during data bit 4, then complete the frame.
  - Required: correct byte delivered.
  - Then assert `rst_n`=0 during data bit 2 of the next frame. Required: IDLE, `busy`=0, `frame_cnt`=0 immediately, with no pulses.
